// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, an optional 2-entry skid buffer,
// multi-source freeze, synchronous flush to a bubble value and saturating stall/flush statistics.
module pipe_stage_reg #(
  parameter int                DATA_W            = 64,
  parameter int                NUM_FRZ           = 2,
  parameter logic [DATA_W-1:0] BUBBLE            = '0,
  parameter bit                SKID_EN           = 1'b1,
  parameter bit                FLUSH_OVER_FREEZE = 1'b0,
  parameter int                CNT_W             = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_FRZ-1:0] freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_p1;
  logic [DATA_W-1:0] main_p1;
  logic [DATA_W-1:0] skid_p1;

  logic frz;
  logic in_fire;
  logic out_fire;
  logic flush_eff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign frz       = |freeze;
  assign flush_eff = flush && (!frz || FLUSH_OVER_FREEZE);

  // With the skid buffer, ready depends only on held state, so out_ready never reaches in_ready.
  assign in_ready  = !reset && !frz &&
                     (SKID_EN ? (state_p1 != TWO) : ((state_p1 == EMPTY) || out_ready));
  assign out_valid = (state_p1 != EMPTY) && !frz;
  assign out_data  = main_p1;
  assign occupancy = state_p1;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Stage boundary: main/skid entries, occupancy state and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1  <= EMPTY;
      main_p1   <= BUBBLE;
      skid_p1   <= BUBBLE;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (frz) stall_cnt <= sat_inc(stall_cnt);
      if (flush_eff) begin
        flush_cnt <= sat_inc(flush_cnt);
        state_p1  <= EMPTY;
        main_p1   <= BUBBLE;
        skid_p1   <= BUBBLE;
      end else begin
        case (state_p1)
          EMPTY: begin
            if (in_fire) begin
              state_p1 <= ONE;
              main_p1  <= in_data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_p1 <= in_data;
            end else if (in_fire && SKID_EN) begin
              state_p1 <= TWO;
              skid_p1  <= in_data;
            end else if (out_fire) begin
              state_p1 <= EMPTY;
              main_p1  <= BUBBLE;
            end
          end
          TWO: begin
            if (out_fire) begin
              state_p1 <= ONE;
              main_p1  <= skid_p1;
              skid_p1  <= BUBBLE;
            end
          end
          default: state_p1 <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three configurations driven in lockstep, a per-instance
// scoreboard queue for the data path, plus direct checks of occupancy, handshake and counters.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  freeze;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;

  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic [63:0] out_data_v  [3];
  logic [1:0]  occ_v       [3];
  logic [15:0] stall_a, flush_a, stall_c, flush_c;
  logic [1:0]  stall_b, flush_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  // a: defaults; b: flush overrides freeze, 2-bit counters; c: no skid buffer
  pipe_stage_reg #(.DATA_W(64), .NUM_FRZ(2), .BUBBLE(64'h0), .SKID_EN(1'b1),
                   .FLUSH_OVER_FREEZE(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
    .occupancy(occ_v[0]), .stall_cnt(stall_a), .flush_cnt(flush_a));

  pipe_stage_reg #(.DATA_W(64), .NUM_FRZ(2), .BUBBLE(64'h0), .SKID_EN(1'b1),
                   .FLUSH_OVER_FREEZE(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
    .occupancy(occ_v[1]), .stall_cnt(stall_b), .flush_cnt(flush_b));

  pipe_stage_reg #(.DATA_W(64), .NUM_FRZ(2), .BUBBLE(64'h0), .SKID_EN(1'b0),
                   .FLUSH_OVER_FREEZE(1'b0), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_v[2]), .in_data(in_data),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(out_data_v[2]),
    .occupancy(occ_v[2]), .stall_cnt(stall_c), .flush_cnt(flush_c));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "simulation did not finish");
  end

  function automatic void q_push(input int d, input logic [63:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [63:0] q_pop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void q_clear(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; scores this cycle's transfers, then advances.
  task automatic tick();
    bit fe;
    #1;
    for (int d = 0; d < 3; d++) begin
      fe = flush && ((d == 1) || (freeze == 2'b00));
      if (fe) begin
        q_clear(d);
      end else begin
        if (out_valid_v[d] && out_ready) begin
          chk($sformatf("d%0d_sb_avail", d), 64'(q_size(d) != 0), 64'd1);
          if (q_size(d) != 0) chk($sformatf("d%0d_sb_data", d), out_data_v[d], q_pop(d));
        end
        if (in_valid && in_ready_v[d]) q_push(d, in_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; freeze = 2'b00; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 64'h0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_out_valid", d), 64'(out_valid_v[d]), 64'd0);
      chk($sformatf("d%0d_rst_in_ready", d), 64'(in_ready_v[d]), 64'd0);
      chk($sformatf("d%0d_rst_occ", d), 64'(occ_v[d]), 64'd0);
      chk($sformatf("d%0d_rst_data", d), out_data_v[d], 64'h0);
    end
    reset = 1'b0;
    #1;
    chk("release_in_ready", 64'(in_ready_v[0]), 64'd1);

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 64'h1; tick();
    chk("stream_occ1", 64'(occ_v[0]), 64'd1);
    chk("stream_data1", out_data_v[0], 64'h1);
    in_data = 64'h2; tick();
    chk("stream_occ2", 64'(occ_v[0]), 64'd1);
    chk("stream_nsk_occ2", 64'(occ_v[2]), 64'd1);
    in_data = 64'h3; tick();
    chk("stream_occ3", 64'(occ_v[0]), 64'd1);
    in_valid = 1'b0; tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_stream_drain_occ", d), 64'(occ_v[d]), 64'd0);
      chk($sformatf("d%0d_stream_drained", d), 64'(q_size(d)), 64'd0);
    end

    // Backpressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'h10; tick();
    in_data = 64'h11; tick();
    in_valid = 1'b0;
    chk("bp_occ", 64'(occ_v[0]), 64'd2);
    chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
    chk("bp_data", out_data_v[0], 64'h10);
    chk("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
    chk("bp_nsk_occ", 64'(occ_v[2]), 64'd1);
    chk("bp_nsk_in_ready", 64'(in_ready_v[2]), 64'd0);
    out_ready = 1'b1; tick();
    chk("bp_drain1_data", out_data_v[0], 64'h11);
    chk("bp_drain1_occ", 64'(occ_v[0]), 64'd1);
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_bp_occ_end", d), 64'(occ_v[d]), 64'd0);
      chk($sformatf("d%0d_bp_drained", d), 64'(q_size(d)), 64'd0);
    end
    chk("bp_bubble", out_data_v[0], 64'h0);

    // Freeze from source 1 holds the entry and blocks both sides
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h20; tick();
    in_data = 64'h99; freeze = 2'b10; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_out_valid", 64'(out_valid_v[0]), 64'd0);
      chk("frz_in_ready", 64'(in_ready_v[0]), 64'd0);
      tick();
    end
    chk("frz_stall_cnt", 64'(stall_a), 64'd3);
    chk("frz_stall_cnt_b", 64'(stall_b), 64'd3);
    chk("frz_stall_cnt_c", 64'(stall_c), 64'd3);
    chk("frz_occ", 64'(occ_v[0]), 64'd1);
    chk("frz_data", out_data_v[0], 64'h20);
    freeze = 2'b00; in_valid = 1'b0; tick();
    chk("frz_release_occ", 64'(occ_v[0]), 64'd0);
    chk("frz_release_q", 64'(q_size(0)), 64'd0);

    // Flush while frozen: ignored by a/c, honoured by b
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h30; tick();
    in_valid = 1'b0; freeze = 2'b01; flush = 1'b1; tick();
    flush = 1'b0;
    chk("ff_keep_occ", 64'(occ_v[0]), 64'd1);
    chk("ff_keep_data", out_data_v[0], 64'h30);
    chk("ff_keep_flush_cnt", 64'(flush_a), 64'd0);
    chk("ff_keep_occ_c", 64'(occ_v[2]), 64'd1);
    chk("ff_over_occ", 64'(occ_v[1]), 64'd0);
    chk("ff_over_data", out_data_v[1], 64'h0);
    chk("ff_over_flush_cnt", 64'(flush_b), 64'd1);
    chk("ff_stall_cnt", 64'(stall_a), 64'd4);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_stall_cnt_b", 64'(stall_b), 64'd3);
    chk("sat_stall_cnt_a", 64'(stall_a), 64'd9);

    // Unfrozen flush discards same-cycle input; then saturate b's flush counter
    freeze = 2'b00; in_valid = 1'b1; in_data = 64'h77; flush = 1'b1; tick();
    in_valid = 1'b0;
    chk("fl_occ", 64'(occ_v[0]), 64'd0);
    chk("fl_data", out_data_v[0], 64'h0);
    chk("fl_flush_cnt", 64'(flush_a), 64'd1);
    chk("fl_flush_cnt_b", 64'(flush_b), 64'd2);
    chk("fl_flush_cnt_c", 64'(flush_c), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b0;
    chk("sat_flush_cnt_b", 64'(flush_b), 64'd3);
    chk("sat_flush_cnt_a", 64'(flush_a), 64'd4);

    // Asynchronous reset in the middle of a full stage
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 64'hA5A5_A5A5_A5A5_A5A5; tick();
    in_data = 64'h5A5A_5A5A_5A5A_5A5A; tick();
    in_valid = 1'b0;
    chk("mid_occ_pre", 64'(occ_v[0]), 64'd2);
    chk("mid_data_pre", out_data_v[0], 64'hA5A5_A5A5_A5A5_A5A5);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("mid_data", out_data_v[0], 64'h0);
    chk("mid_occ", 64'(occ_v[0]), 64'd0);
    chk("mid_stall_cnt", 64'(stall_a), 64'd0);
    chk("mid_flush_cnt", 64'(flush_a), 64'd0);
    chk("mid_in_ready", 64'(in_ready_v[0]), 64'd0);
    chk("mid_flush_cnt_b", 64'(flush_b), 64'd0);
    for (int d = 0; d < 3; d++) q_clear(d);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_release_in_ready", 64'(in_ready_v[0]), 64'd1);
    tick();
    chk("mid_release_occ", 64'(occ_v[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline-stage register, the successor to the fixed 32-bit PC/instruction stage registers.
- Carries a DATA_W-bit payload between pipeline stages with a valid/ready handshake and an optional 2-entry skid buffer.
- Supports OR-combined multi-source freeze, synchronous flush to a bubble value, and saturating stall/flush counters.
- Used between IF/ID/EX/MEM/WB; the payload is concatenated PC, instruction and control bits.

Parameters:
DATA_W, 64, payload width in bits
NUM_FRZ, 2, number of freeze sources (e.g. hazard unit, SRAM wait)
BUBBLE, 0, value of out_data after reset/flush/drain (DATA_W bits)
SKID_EN, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single entry
FLUSH_OVER_FREEZE, 0, 1 = flush takes effect even while frozen
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
freeze  input  NUM_FRZ  freeze requests, OR-reduced to frz
flush  input  1  synchronous flush of all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  payload presented downstream
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload (main entry)
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with frz=1, saturating
flush_cnt  output  CNT_W  accepted flushes, saturating

Behaviour:
- Reset (async, any time including mid-transfer): state=EMPTY; main=skid=BUBBLE; counters=0; out_valid=0; in_ready=0 during reset, 1 on the first cycle after release if frz=0.
- frz = |freeze. in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main valid), TWO (main+skid valid; SKID_EN=1 only). occupancy = 0/1/2.
- out_valid = (state!=EMPTY) & !frz. out_data = main (BUBBLE when EMPTY).
- in_ready, SKID_EN=1: !frz & (state!=TWO). No combinational path from out_ready.
- in_ready, SKID_EN=0: !frz & (state==EMPTY | out_ready).
- Transitions (frz=0, flush=0):
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire only -> TWO, skid<=in_data (SKID_EN=0: cannot occur). out_fire only -> EMPTY, main<=BUBBLE.
  - TWO: out_fire -> ONE, main<=skid, skid<=BUBBLE. Otherwise hold.
- Latency: one cycle from in_fire to out_valid. Full throughput of 1 transfer/cycle in both modes. Order is preserved.
- Freeze: frz=1 holds all state, main and skid unchanged. No transfer occurs on either side because the in_ready and out_valid gating prevents it.
- Flush, effective when flush & (!frz | FLUSH_OVER_FREEZE):
  - Next state=EMPTY; main=skid=BUBBLE; the in_data of the same cycle is discarded.
  - out_valid in the flush cycle still follows the rule above; the downstream must ignore it or the stage is flushed together.
  - Flush ignored while frozen when FLUSH_OVER_FREEZE=0.
- flush_cnt increments per effective flush. stall_cnt increments each cycle frz=1. Both saturate at 2^CNT_W-1; neither wraps.
- Simultaneous in_fire and out_fire in TWO is impossible because in_ready=0 in TWO.
- Synthesisable; no X on outputs after reset.

Test Plan:
- Reset mid-stream: state TWO holding A5A5.. and 5A5A.., assert reset -> out_valid=0, out_data=0, occupancy=0, counters=0 immediately.
- Streaming, out_ready=1: push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, occupancy stays 1.
- Backpressure (SKID_EN=1): push 0x10, 0x11 with out_ready=0:
  - occupancy=2, in_ready=0, out_data=0x10.
  - Raise out_ready -> 0x10 then 0x11 are delivered, occupancy returns to 0.
- Freeze: freeze=2'b10 for 3 cycles holding 0x20 -> out_valid=0, in_ready=0, data held, stall_cnt=3; on release 0x20 delivered.
- Flush priority: flush with freeze=1:
  - FLUSH_OVER_FREEZE=0 -> entry kept, flush_cnt=0.
  - FLUSH_OVER_FREEZE=1 -> occupancy=0, out_data=BUBBLE, flush_cnt=1.
- Saturation: CNT_W=2, hold freeze for 6 cycles -> stall_cnt stops at 3.
